// File: rtl/game_pkg.sv
// Shared tic-tac-toe encodings: cell codes, outcome codes, sequencing states
// and cell indices, used by move_ctrl and the outcome checker.
package game_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] P1    = 2'b01;
    localparam logic [1:0] P2    = 2'b10;

    localparam logic [1:0] IN_PROGRESS = 2'd0;
    localparam logic [1:0] P1_WIN      = 2'd1;
    localparam logic [1:0] P1_LOSE     = 2'd2;
    localparam logic [1:0] TIE         = 2'd3;

    typedef enum logic [1:0] {
        S_TURN      = 2'd0,
        S_CHECK     = 2'd1,
        S_GAME_OVER = 2'd2
    } state_t;

    localparam int N_CELLS = 9;
    localparam int A1 = 0;
    localparam int A2 = 1;
    localparam int A3 = 2;
    localparam int B1 = 3;
    localparam int B2 = 4;
    localparam int B3 = 5;
    localparam int C1 = 6;
    localparam int C2 = 7;
    localparam int C3 = 8;

    localparam logic [3:0] LAST_CELL = 4'd8;
    localparam logic [3:0] MAX_MOVES = 4'd9;

    function automatic logic [1:0] player_code(input int player);
        return (player == 2) ? P2 : P1;
    endfunction

    function automatic logic [1:0] other_player(input logic [1:0] code);
        return (code == P1) ? P2 : P1;
    endfunction

endpackage

// File: rtl/move_ctrl_rise_det.sv
// Registered rising-edge detector: one-cycle pulse while sig is high and
// was low at the previous clock edge.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/move_ctrl.sv
// Turn sequencing and board storage ahead of the outcome checker: accepts one
// move per button press, rejects illegal ones, latches the final outcome.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_TURN      | waiting for a move request from the player in turn
// S_CHECK     | move written; sample outcome_in, then pass turn or end game
// S_GAME_OVER | result latched, board frozen until new_game or rst
module move_ctrl
    import game_pkg::*;
#(
    parameter int FIRST_PLAYER = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cell_sel,
    input  logic       place,
    input  logic       new_game,
    input  logic [1:0] outcome_in,
    output logic [1:0] A1_val,
    output logic [1:0] A2_val,
    output logic [1:0] A3_val,
    output logic [1:0] B1_val,
    output logic [1:0] B2_val,
    output logic [1:0] B3_val,
    output logic [1:0] C1_val,
    output logic [1:0] C2_val,
    output logic [1:0] C3_val,
    output logic [1:0] turn,
    output logic [1:0] result,
    output logic [3:0] move_count,
    output logic       illegal,
    output logic       busy
);

    localparam logic [1:0] FIRST_CODE = player_code(FIRST_PLAYER);

    state_t     state_q, state_nxt;
    logic [1:0] cells_q   [N_CELLS];
    logic [1:0] cells_nxt [N_CELLS];
    logic [1:0] turn_q, turn_nxt;
    logic [1:0] result_q, result_nxt;
    logic [3:0] count_q, count_nxt;
    logic       illegal_q, illegal_nxt;
    logic       req;
    logic       sel_free;

    rise_det u_rise_det (
        .clk  (clk),
        .rst  (rst),
        .sig  (place),
        .rise (req)
    );

    // Occupancy lookup without indexing past the array for codes 9..15.
    always_comb begin
        sel_free = 1'b0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cell_sel == 4'(i) && cells_q[i] == EMPTY) begin
                sel_free = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cells_nxt   = cells_q;
        turn_nxt    = turn_q;
        result_nxt  = result_q;
        count_nxt   = count_q;
        illegal_nxt = 1'b0;

        if (new_game) begin
            for (int i = 0; i < N_CELLS; i++) begin
                cells_nxt[i] = EMPTY;
            end
            turn_nxt   = FIRST_CODE;
            result_nxt = IN_PROGRESS;
            count_nxt  = 4'd0;
            state_nxt  = S_TURN;
        end else begin
            case (state_q)
                S_TURN: begin
                    if (req) begin
                        if (cell_sel <= LAST_CELL && sel_free) begin
                            for (int i = 0; i < N_CELLS; i++) begin
                                if (cell_sel == 4'(i)) begin
                                    cells_nxt[i] = turn_q;
                                end
                            end
                            count_nxt = count_q + 4'd1;
                            state_nxt = S_CHECK;
                        end else begin
                            illegal_nxt = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (outcome_in != IN_PROGRESS) begin
                        result_nxt = outcome_in;
                        turn_nxt   = EMPTY;
                        state_nxt  = S_GAME_OVER;
                    end else if (count_q == MAX_MOVES) begin
                        // Full board ends the game even if the checker misses the tie.
                        result_nxt = TIE;
                        turn_nxt   = EMPTY;
                        state_nxt  = S_GAME_OVER;
                    end else begin
                        turn_nxt  = other_player(turn_q);
                        state_nxt = S_TURN;
                    end
                end
                S_GAME_OVER: begin
                    state_nxt = S_GAME_OVER;
                end
                default: begin
                    state_nxt = S_TURN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_TURN;
            turn_q    <= FIRST_CODE;
            result_q  <= IN_PROGRESS;
            count_q   <= 4'd0;
            illegal_q <= 1'b0;
            for (int i = 0; i < N_CELLS; i++) begin
                cells_q[i] <= EMPTY;
            end
        end else begin
            state_q   <= state_nxt;
            turn_q    <= turn_nxt;
            result_q  <= result_nxt;
            count_q   <= count_nxt;
            illegal_q <= illegal_nxt;
            for (int i = 0; i < N_CELLS; i++) begin
                cells_q[i] <= cells_nxt[i];
            end
        end
    end

    assign A1_val     = cells_q[A1];
    assign A2_val     = cells_q[A2];
    assign A3_val     = cells_q[A3];
    assign B1_val     = cells_q[B1];
    assign B2_val     = cells_q[B2];
    assign B3_val     = cells_q[B3];
    assign C1_val     = cells_q[C1];
    assign C2_val     = cells_q[C2];
    assign C3_val     = cells_q[C3];
    assign turn       = turn_q;
    assign result     = result_q;
    assign move_count = count_q;
    assign illegal    = illegal_q;
    assign busy       = (state_q != S_TURN);

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: directed games from the plan plus random button/
// new_game/checker traffic, all compared against a board-level game model.
module tb_move_ctrl;

    localparam int FP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cell_sel = 4'd0;
    logic       place = 1'b0;
    logic       new_game = 1'b0;
    logic [1:0] outcome_in = 2'd0;
    logic [1:0] A1_val, A2_val, A3_val, B1_val, B2_val, B3_val, C1_val, C2_val, C3_val;
    logic [1:0] turn, result;
    logic [3:0] move_count;
    logic       illegal, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: board contents, whose move, and whether a move awaits judging.
    int board [9];
    int m_player;
    int m_result;
    int m_moves;
    bit m_illegal;
    bit m_judging;
    bit m_over;
    bit m_btn_prev;

    move_ctrl #(.FIRST_PLAYER(FP)) dut (
        .clk        (clk),
        .rst        (rst),
        .cell_sel   (cell_sel),
        .place      (place),
        .new_game   (new_game),
        .outcome_in (outcome_in),
        .A1_val     (A1_val),
        .A2_val     (A2_val),
        .A3_val     (A3_val),
        .B1_val     (B1_val),
        .B2_val     (B2_val),
        .B3_val     (B3_val),
        .C1_val     (C1_val),
        .C2_val     (C2_val),
        .C3_val     (C3_val),
        .turn       (turn),
        .result     (result),
        .move_count (move_count),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) board[i] = 0;
        m_player   = FP;
        m_result   = 0;
        m_moves    = 0;
        m_illegal  = 1'b0;
        m_judging  = 1'b0;
        m_over     = 1'b0;
        m_btn_prev = 1'b0;
    endtask

    task automatic model_clear_game();
        for (int i = 0; i < 9; i++) board[i] = 0;
        m_player  = FP;
        m_result  = 0;
        m_moves   = 0;
        m_judging = 1'b0;
        m_over    = 1'b0;
    endtask

    // One clock edge of game rules, using the inputs present at the edge.
    task automatic model_edge();
        bit pressed;
        pressed    = place && !m_btn_prev;
        m_btn_prev = place;
        m_illegal  = 1'b0;
        if (new_game) begin
            model_clear_game();
        end else if (m_judging) begin
            m_judging = 1'b0;
            if (outcome_in != 0) begin
                m_result = int'(outcome_in);
                m_over   = 1'b1;
            end else if (m_moves == 9) begin
                m_result = 3;
                m_over   = 1'b1;
            end else begin
                m_player = (m_player == 1) ? 2 : 1;
            end
        end else if (!m_over && pressed) begin
            if (cell_sel < 9 && board[cell_sel] == 0) begin
                board[cell_sel] = m_player;
                m_moves++;
                m_judging = 1'b1;
            end else begin
                m_illegal = 1'b1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [17:0] obs_cells, exp_cells;
        obs_cells = {A1_val, A2_val, A3_val, B1_val, B2_val, B3_val, C1_val, C2_val, C3_val};
        for (int i = 0; i < 9; i++) exp_cells[17-2*i -: 2] = 2'(board[i]);
        check_eq({tag, ".cells"},   32'(obs_cells),  32'(exp_cells));
        check_eq({tag, ".turn"},    32'(turn),       m_over ? 32'd0 : 32'(m_player));
        check_eq({tag, ".result"},  32'(result),     32'(m_result));
        check_eq({tag, ".moves"},   32'(move_count), 32'(m_moves));
        check_eq({tag, ".illegal"}, 32'(illegal),    32'(m_illegal));
        check_eq({tag, ".busy"},    32'(busy),       32'(m_judging || m_over));
    endtask

    task automatic cycle(input string tag, input logic p, input logic [3:0] c,
                         input logic ng, input logic [1:0] oc);
        place      = p;
        cell_sel   = c;
        new_game   = ng;
        outcome_in = oc;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    // Press then release; outcome_in is applied on the release cycle (CHECK).
    task automatic play(input string tag, input logic [3:0] c, input logic [1:0] oc);
        cycle(tag, 1'b1, c, 1'b0, 2'd0);
        cycle(tag, 1'b0, c, 1'b0, oc);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #12;
        check_eq("rst.cells", 32'({A1_val, A2_val, A3_val, B1_val, B2_val, B3_val,
                                   C1_val, C2_val, C3_val}), 32'd0);
        check_eq("rst.turn",  32'(turn), 32'd1);
        check_eq("rst.busy",  32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First move at B2, then pass turn to P2.
        cycle("b2_press", 1'b1, 4'd4, 1'b0, 2'd0);
        check_eq("b2.val",  32'(B2_val), 32'd1);
        check_eq("b2.busy", 32'(busy),   32'd1);
        cycle("b2_check", 1'b0, 4'd4, 1'b0, 2'd0);
        check_eq("b2.turn", 32'(turn), 32'd2);

        // Occupied cell and invalid index.
        cycle("occ_press", 1'b1, 4'd4, 1'b0, 2'd0);
        check_eq("occ.illegal", 32'(illegal), 32'd1);
        cycle("occ_rel", 1'b0, 4'd4, 1'b0, 2'd0);
        check_eq("occ.pulse_end", 32'(illegal), 32'd0);
        cycle("bad_press", 1'b1, 4'd12, 1'b0, 2'd0);
        check_eq("bad.illegal", 32'(illegal), 32'd1);
        cycle("bad_rel", 1'b0, 4'd12, 1'b0, 2'd0);

        // P1 wins across the top row.
        cycle("ng1", 1'b0, 4'd0, 1'b1, 2'd0);
        play("w0", 4'd0, 2'd0);
        play("w3", 4'd3, 2'd0);
        play("w1", 4'd1, 2'd0);
        play("w4", 4'd4, 2'd0);
        play("w2", 4'd2, 2'd1);
        check_eq("win.result", 32'(result), 32'd1);
        check_eq("win.turn",   32'(turn),   32'd0);
        play("win_frozen", 4'd8, 2'd0);
        check_eq("win.frozen_c3", 32'(C3_val), 32'd0);

        // Full board with the checker silent: tie backstop.
        cycle("ng2", 1'b0, 4'd0, 1'b1, 2'd0);
        for (int i = 0; i < 9; i++) play("tie", 4'(i), 2'd0);
        check_eq("tie.result", 32'(result), 32'd3);
        check_eq("tie.moves",  32'(move_count), 32'd9);

        // new_game beats a same-cycle press; held button must not fire afterwards.
        cycle("ng3", 1'b0, 4'd0, 1'b1, 2'd0);
        play("mid0", 4'd0, 2'd0);
        cycle("ng_press", 1'b1, 4'd5, 1'b1, 2'd0);
        check_eq("ng.moves", 32'(move_count), 32'd0);
        cycle("ng_hold", 1'b1, 4'd5, 1'b0, 2'd0);
        check_eq("ng.hold_b3", 32'(B3_val), 32'd0);
        cycle("ng_rel", 1'b0, 4'd5, 1'b0, 2'd0);

        // Reset arriving during CHECK clears at once.
        cycle("rc_press", 1'b1, 4'd6, 1'b0, 2'd0);
        place = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst_mid_check");
        @(negedge clk);
        rst = 1'b0;

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            logic       p, ng;
            logic [3:0] c;
            logic [1:0] oc;
            p  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            ng = ($urandom_range(0, 59) == 0);
            oc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cycle("rand", p, c, ng, oc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
